// File: rtl/free_list_pkg.sv
// Shared rename/ROB/free-list definitions so every block agrees on widths.
package free_list_pkg;

  localparam int FL_PREG_WIDTH = 7;   // 2^7 = 128 physical registers
  localparam int FL_ROB_WIDTH  = 4;   // 16 ROB tags / checkpoint slots
  localparam int FL_NUM_AREGS  = 32;  // architectural registers

  typedef logic [FL_PREG_WIDTH-1:0] preg_t;
  typedef logic [FL_ROB_WIDTH-1:0]  rob_tag_t;
  typedef logic [FL_PREG_WIDTH:0]   fl_ptr_t;  // read/write pointer with wrap bit

endpackage

// File: rtl/free_list_ckpt_table.sv
// Checkpoint table: one saved free-list read pointer per ROB tag.
// Single write port, asynchronous read so a mispredict restores in one cycle.
module ckpt_table
  import free_list_pkg::*;
#(
  parameter int ADDR_W = FL_ROB_WIDTH,
  parameter int DATA_W = FL_PREG_WIDTH + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int SLOTS = 1 << ADDR_W;

  logic [DATA_W-1:0] slots_q [SLOTS];
  logic [DATA_W-1:0] slots_d [SLOTS];

  // Next-state for the slot array: only the addressed slot changes.
  always_comb begin
    slots_d = slots_q;
    if (i_wr_en) begin
      slots_d[i_wr_addr] = i_wr_data;
    end
  end

  // Slot storage; every slot clears to pointer 0 on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      slots_q <= slots_d;
    end
  end

  assign o_rd_data = slots_q[i_rd_addr];

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical registers. Rename pops from the head, commit
// pushes retired old mappings at the tail, and per-branch checkpoints of the
// read pointer let a mispredict hand back every preg allocated after it.
module free_list
  import free_list_pkg::*;
#(
  parameter int PREG_WIDTH = FL_PREG_WIDTH,
  parameter int ROB_WIDTH  = FL_ROB_WIDTH,
  parameter int NUM_AREGS  = FL_NUM_AREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_alloc_req,
  output logic                  o_alloc_valid,
  output logic [PREG_WIDTH-1:0] o_alloc_preg,
  input  logic                  i_ckpt_valid,
  input  logic [ROB_WIDTH-1:0]  i_ckpt_rob_tag,
  input  logic                  i_free_valid,
  input  logic [PREG_WIDTH-1:0] i_free_preg,
  input  logic                  i_mispredict,
  input  logic [ROB_WIDTH-1:0]  i_mispredict_rob_tag,
  output logic [PREG_WIDTH:0]   o_count
);

  localparam int FIFO_DEPTH = 1 << PREG_WIDTH;
  localparam int INIT_FREE  = FIFO_DEPTH - NUM_AREGS;

  logic [PREG_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PREG_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PREG_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [PREG_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [PREG_WIDTH:0]   count;
  logic [PREG_WIDTH:0]   rd_ptr_adv;
  logic [PREG_WIDTH:0]   ckpt_rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  ckpt_wr_en;

  // Checkpoints store the read pointer as it will be after this cycle's pop,
  // so a branch that itself allocates keeps its own destination on recovery.
  ckpt_table #(
    .ADDR_W (ROB_WIDTH),
    .DATA_W (PREG_WIDTH + 1)
  ) u_ckpt_table (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (ckpt_wr_en),
    .i_wr_addr (i_ckpt_rob_tag),
    .i_wr_data (rd_ptr_adv),
    .i_rd_addr (i_mispredict_rob_tag),
    .o_rd_data (ckpt_rd_ptr)
  );

  // Pointer arithmetic, outputs and next-state. Mispredict owns rd_ptr;
  // pushes still land because committing instructions predate the branch.
  always_comb begin
    count         = wr_ptr_q - rd_ptr_q;
    o_count       = count;
    o_alloc_valid = (count != '0);
    o_alloc_preg  = mem_q[rd_ptr_q[PREG_WIDTH-1:0]];

    pop        = i_alloc_req && o_alloc_valid && !i_mispredict;
    push       = i_free_valid && (i_free_preg != '0);
    ckpt_wr_en = i_ckpt_valid && !i_mispredict;

    rd_ptr_adv = rd_ptr_q + {{PREG_WIDTH{1'b0}}, pop};
    rd_ptr_d   = i_mispredict ? ckpt_rd_ptr : rd_ptr_adv;
    wr_ptr_d   = wr_ptr_q + {{PREG_WIDTH{1'b0}}, push};

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PREG_WIDTH-1:0]] = i_free_preg;
    end
  end

  // State registers; reset loads every non-architectural preg into the list.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= (PREG_WIDTH + 1)'(INIT_FREE);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= (i < INIT_FREE) ? PREG_WIDTH'(NUM_AREGS + i) : '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Simulation checks: a push into a full list or an out-of-range preg
  // means rename/commit bookkeeping has gone wrong upstream.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (count != (PREG_WIDTH + 1)'(FIFO_DEPTH));
      assert (int'(i_free_preg) < FIFO_DEPTH);
    end
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register numbers, shared by rename and commit.
- Rename pops one new physical destination per cycle. Commit pushes back the old mapping retired by the ROB (ROB commit old-preg output, 0 = nothing to free).
- Per-ROB-tag checkpoints of the read pointer let a branch mispredict restore, in one cycle, every preg handed out after the branch.

Parameters:
- PREG_WIDTH, 7, physical register index width (2^PREG_WIDTH pregs).
- ROB_WIDTH, 4, ROB tag width (2^ROB_WIDTH checkpoint slots).
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are the reset identity mapping and never start in the list.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_alloc_req  in  1  rename pops one preg this cycle (instruction writes rd != x0).
- o_alloc_valid  out  1  list non-empty; a pop is honoured only when 1.
- o_alloc_preg  out  PREG_WIDTH  preg at head of list (combinational from storage).
- i_ckpt_valid  in  1  branch dispatched this cycle; save a checkpoint.
- i_ckpt_rob_tag  in  ROB_WIDTH  ROB tag of that branch.
- i_free_valid  in  1  ROB commit valid.
- i_free_preg  in  PREG_WIDTH  ROB commit old preg; value 0 is ignored.
- i_mispredict  in  1  branch mispredict recovery.
- i_mispredict_rob_tag  in  ROB_WIDTH  tag of the mispredicted branch.
- o_count  out  PREG_WIDTH+1  number of free pregs.

Behaviour:
- Storage: FIFO_DEPTH = 2^PREG_WIDTH entries of PREG_WIDTH bits. rd_ptr and wr_ptr are PREG_WIDTH+1 bits (extra wrap bit). count = wr_ptr - rd_ptr, modulo 2^(PREG_WIDTH+1).
- Reset:
  - entry i = NUM_AREGS+i for i in 0..FIFO_DEPTH-NUM_AREGS-1.
  - rd_ptr = 0, wr_ptr = FIFO_DEPTH-NUM_AREGS.
  - With defaults: o_count = 96, o_alloc_valid = 1, o_alloc_preg = 32.
  - All checkpoint slots = 0.
- o_alloc_valid = (count != 0). o_alloc_preg = mem[rd_ptr[PREG_WIDTH-1:0]], valid in the same cycle (0-cycle read).
- Pop: i_alloc_req && o_alloc_valid && !i_mispredict -> rd_ptr += 1 at the edge.
  - i_alloc_req while empty is ignored; rename must stall.
- Push: i_free_valid && i_free_preg != 0 -> mem[wr_ptr] <= i_free_preg; wr_ptr += 1.
  - Pushes happen even during a mispredict, because commits are always older than the branch.
  - No bypass: a preg pushed into an empty list is visible the next cycle.
- Checkpoint: i_ckpt_valid && !i_mispredict -> ckpt[i_ckpt_rob_tag] <= rd_ptr value after this cycle's pop (rd_ptr+1 if a pop also occurs). This covers a JAL-type branch that also allocates.
- Mispredict (highest priority on rd_ptr):
  - rd_ptr <= ckpt[i_mispredict_rob_tag].
  - Concurrent pop and checkpoint are dropped. Concurrent push is still applied.
  - No entry between the checkpoint and the current rd_ptr can have been overwritten, because total live pregs never exceed FIFO_DEPTH.
- Simultaneous pop + push with count = 1: both occur; count stays 1 and the head becomes the pushed preg.
- Wrap-around: the low PREG_WIDTH bits index storage. Wrap bits must make count correct across wrap (e.g. wr = 8'h02 style, rd near top).
- Overflow: a push when count == FIFO_DEPTH is illegal; the implementation must carry a simulation assertion for it. Also assert i_free_preg < 2^PREG_WIDTH when freeing.
- o_count is registered-state-derived (combinational from pointers); it changes only at clock edges.

Decomposition:
- Shared package holds PREG_WIDTH/ROB_WIDTH defaults, NUM_AREGS, and the preg_t/rob_tag_t typedefs, so rename, ROB and free_list agree.
- Checkpoint RAM (2^ROB_WIDTH x PREG_WIDTH+1, 1 write/1 async read) is a natural sub-module: ckpt_table.
- FIFO logic stays in free_list.

Test Plan:
- Reset, then hold i_alloc_req 3 cycles -> o_alloc_preg 32, 33, 34 on successive cycles; o_count 96 -> 93.
- Drain all 96 (o_alloc_valid drops to 0 after 96 pops, o_count = 0); push 40 -> o_alloc_valid 1 and o_alloc_preg 40 the next cycle, not the same cycle.
- i_free_valid = 1 with i_free_preg = 0 -> o_count unchanged. Pop and push(50) in the same cycle -> count unchanged, 50 appended at the tail.
- Pop 32; checkpoint tag 5 (rd_ptr = 1); pop 33, 34 -> i_mispredict with tag 5 -> next cycle o_alloc_preg = 33, o_count restored to 95.
- Mispredict asserted together with i_alloc_req, i_ckpt_valid and push(60) -> pop and checkpoint ignored, 60 appended, rd_ptr = checkpoint.
- Long random pop/push run of more than 300 ops crossing the pointer wrap -> list contents match a reference queue; no duplicate pregs are ever live.
